// File: rtl/io_misc_gpio_if.sv
// Wishbone interface shared by the io_* peripheral slaves.
// dat_m is driven by the master and dat_s by the slave.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;

    modport slave (
        input  cyc,
        input  stb,
        input  we,
        input  adr,
        input  dat_m,
        output dat_s,
        output ack,
        output stall
    );

    modport master (
        output cyc,
        output stb,
        output we,
        output adr,
        output dat_m,
        input  dat_s,
        input  ack,
        input  stall
    );
endinterface

// File: rtl/io_misc_gpio.sv
// io_misc_gpio: Wishbone misc I/O slave with an LED register, synchronised
// general inputs with edge-detect interrupts, the boot_time value and a
// free-running cycle counter.
module io_misc_gpio #(
    parameter int unsigned NLED        = 1,
    parameter int unsigned NIN         = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    if_wb.slave             bus,
    output logic [NLED-1:0] led,
    input  logic [NIN-1:0]  gpio_in,
    input  logic [32:0]     boot_time,
    output logic            irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Register indices decoded from bus.adr[4:2]
    localparam logic [2:0] A_LED      = 3'd0;
    localparam logic [2:0] A_IN       = 3'd1;
    localparam logic [2:0] A_STATUS   = 3'd2;
    localparam logic [2:0] A_ENABLE   = 3'd3;
    localparam logic [2:0] A_POL      = 3'd4;
    localparam logic [2:0] A_BOOT_LO  = 3'd5;
    localparam logic [2:0] A_BOOT_HI  = 3'd6;
    localparam logic [2:0] A_CYCLES   = 3'd7;

    state_t state;
    state_t state_nxt;

    logic [31:0] result;
    logic [31:0] rd_data;
    logic [31:0] cycles;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0] in_sync;
    logic [NIN-1:0] prev_q;
    logic [NIN-1:0] rise;
    logic [NIN-1:0] fall;
    logic [NIN-1:0] edge_det;
    logic [NIN-1:0] w1c_clr;

    logic [NIN-1:0] irq_status;
    logic [NIN-1:0] irq_enable;
    logic [NIN-1:0] edge_pol;

    logic       access;
    logic       wr_access;
    logic [2:0] reg_sel;
    logic       unused_bits;

    assign access    = (state == S_BUSY);
    assign wr_access = access & bus.we;
    assign reg_sel   = bus.adr[4:2];
    assign in_sync   = sync_q[SYNC_STAGES-1];

    // Address/data bits outside the decoded fields are don't-care
    assign unused_bits = ^{bus.adr, bus.dat_m};

    // Bus state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus next-state: accept, perform the access, acknowledge
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.cyc && bus.stb) state_nxt = S_BUSY;
            S_BUSY:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs: ack only in S_DONE, read data held in result
    always_comb begin
        bus.ack   = (state == S_DONE);
        bus.stall = 1'b0;
        bus.dat_s = result;
    end

    // Read multiplexer, zero-extending the narrow registers
    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            A_LED:     rd_data[NLED-1:0] = led;
            A_IN:      rd_data[NIN-1:0]  = in_sync;
            A_STATUS:  rd_data[NIN-1:0]  = irq_status;
            A_ENABLE:  rd_data[NIN-1:0]  = irq_enable;
            A_POL:     rd_data[NIN-1:0]  = edge_pol;
            A_BOOT_LO: rd_data           = boot_time[31:0];
            A_BOOT_HI: rd_data[0]        = boot_time[32];
            A_CYCLES:  rd_data           = cycles;
            default:   rd_data           = '0;
        endcase
    end

    // Per-bit edge selection and the write-one-to-clear mask
    always_comb begin
        rise     = in_sync & ~prev_q;
        fall     = ~in_sync & prev_q;
        edge_det = (edge_pol & fall) | (~edge_pol & rise);
        w1c_clr  = '0;
        if (wr_access && (reg_sel == A_STATUS)) begin
            w1c_clr = bus.dat_m[NIN-1:0];
        end
    end

    // Input synchroniser chain and previous-sample history
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= in_sync;
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // Register file: writes and read capture happen on the S_BUSY edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            led        <= '0;
            irq_enable <= '0;
            edge_pol   <= '0;
            result     <= '0;
        end else if (access) begin
            if (bus.we) begin
                result <= '0;
                unique case (reg_sel)
                    A_LED:    led        <= bus.dat_m[NLED-1:0];
                    A_ENABLE: irq_enable <= bus.dat_m[NIN-1:0];
                    A_POL:    edge_pol   <= bus.dat_m[NIN-1:0];
                    default:  ;
                endcase
            end else begin
                result <= rd_data;
            end
        end
    end

    // Sticky status: an edge on the same cycle as a clear keeps the bit set
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c_clr) | edge_det;
        end
    end

    // Registered level interrupt from the enabled status bits
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_status & irq_enable);
        end
    end

endmodule
